// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its checkers: opcodes, compare codes and
// the result-monitor FSM encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFail = 2'd2
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected-result function for the alu; checked is low for the
// reserved opcode.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [1:0]          opcode,
  input  logic signed [N-1:0] data1,
  input  logic signed [N-1:0] data2,
  output logic signed [N:0]   expected,
  output logic                checked
);

  logic signed [N:0] a_ext;
  logic signed [N:0] b_ext;

  assign a_ext = {data1[N-1], data1};
  assign b_ext = {data2[N-1], data2};

  always_comb begin
    expected = '0;
    checked  = 1'b1;
    unique case (opcode)
      OP_ADD: expected = a_ext + b_ext;
      OP_SUB: expected = a_ext - b_ext;
      OP_CMP: begin
        if (data1 > data2)      expected = (N+1)'(CMP_GT);
        else if (data1 < data2) expected = (N+1)'(CMP_LT);
        else                    expected = (N+1)'(CMP_EQ);
      end
      OP_RSV: checked = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_check_mon.sv
// ALU result monitor: latency-aligned expected results, registered compare,
// saturating pass/fail counters and a sticky first-mismatch record.
module alu_check_mon
  import alu_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 1,
  parameter int unsigned CW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [1:0]          opcode,
  input  logic signed [N-1:0] data1,
  input  logic signed [N-1:0] data2,
  input  logic signed [N:0]   y,
  input  logic                clr_stats,
  output logic [CW-1:0]       pass_cnt,
  output logic [CW-1:0]       fail_cnt,
  output logic                err,
  output logic [1:0]          err_opcode,
  output logic signed [N:0]   err_expected,
  output logic signed [N:0]   err_actual,
  output logic [1:0]          state
);

  logic signed [N:0] exp_now;
  logic              chk_now;

  alu_ref_model #(.N(N)) u_ref (
    .opcode   (opcode),
    .data1    (data1),
    .data2    (data2),
    .expected (exp_now),
    .checked  (chk_now)
  );

  logic              vld_q [LAT];
  logic [1:0]        op_q  [LAT];
  logic signed [N:0] exp_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        vld_q[i] <= 1'b0;
        op_q[i]  <= '0;
        exp_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= ena & chk_now;
      op_q[0]  <= opcode;
      exp_q[0] <= exp_now;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        op_q[i]  <= op_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  // Compare stage; a clear drops the result registered on the same edge.
  logic              cmp_vld_q;
  logic              cmp_pass_q;
  logic [1:0]        cmp_op_q;
  logic signed [N:0] cmp_exp_q;
  logic signed [N:0] cmp_act_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_vld_q  <= 1'b0;
      cmp_pass_q <= 1'b0;
      cmp_op_q   <= '0;
      cmp_exp_q  <= '0;
      cmp_act_q  <= '0;
    end else begin
      cmp_vld_q  <= vld_q[LAT-1] & ~clr_stats;
      cmp_pass_q <= (y == exp_q[LAT-1]);
      cmp_op_q   <= op_q[LAT-1];
      cmp_exp_q  <= exp_q[LAT-1];
      cmp_act_q  <= y;
    end
  end

  chk_state_e        state_q, state_d;
  logic [CW-1:0]     pass_q, pass_d, fail_q, fail_d;
  logic [1:0]        eop_q, eop_d;
  logic signed [N:0] eexp_q, eexp_d, eact_q, eact_d;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    eop_d   = eop_q;
    eexp_d  = eexp_q;
    eact_d  = eact_q;
    if (clr_stats) begin
      state_d = StIdle;
      pass_d  = '0;
      fail_d  = '0;
      eop_d   = '0;
      eexp_d  = '0;
      eact_d  = '0;
    end else if (cmp_vld_q) begin
      if (cmp_pass_q) begin
        if (pass_q != '1) pass_d = pass_q + 1'b1;
        if (state_q == StIdle) state_d = StRun;
      end else begin
        if (fail_q != '1) fail_d = fail_q + 1'b1;
        if (state_q != StFail) begin
          state_d = StFail;
          eop_d   = cmp_op_q;
          eexp_d  = cmp_exp_q;
          eact_d  = cmp_act_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pass_q  <= '0;
      fail_q  <= '0;
      eop_q   <= '0;
      eexp_q  <= '0;
      eact_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      eop_q   <= eop_d;
      eexp_q  <= eexp_d;
      eact_q  <= eact_d;
    end
  end

  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign err          = (state_q == StFail);
  assign err_opcode   = eop_q;
  assign err_expected = eexp_q;
  assign err_actual   = eact_q;
  assign state        = state_q;

endmodule
